// File: rtl/seq_arith_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_arith_unit_if                                               |
// | Purpose  : Request/response bundle for seq_arith_unit. The slave modport   |
// |            is the arithmetic unit's view; the master modport is the       |
// |            requester/consumer's view.                                      |
// | Signals  : i_valid, o_ready            request handshake                   |
// |            i_op, i_value_a, i_value_b  request payload                     |
// |            o_valid, i_ready            response handshake                  |
// |            o_value, o_value_rem,       response payload                    |
// |            o_flag                                                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface seq_arith_unit_if #(
   parameter int DATA_W = 8
);
   logic              i_valid;
   logic              o_ready;
   logic [1:0]        i_op;
   logic [DATA_W-1:0] i_value_a;
   logic [DATA_W-1:0] i_value_b;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_value;
   logic [DATA_W-1:0] o_value_rem;
   logic              o_flag;

   modport slave (
      input  i_valid, i_op, i_value_a, i_value_b, i_ready,
      output o_ready, o_valid, o_value, o_value_rem, o_flag
   );

   modport master (
      output i_valid, i_op, i_value_a, i_value_b, i_ready,
      input  o_ready, o_valid, o_value, o_value_rem, o_flag
   );
endinterface
`default_nettype wire

// File: rtl/seq_arith_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_arith_unit                                                  |
// | Purpose  : Registered unsigned add / sub / mul / div unit. Add, sub, mul   |
// |            and divide-by-zero complete one cycle after acceptance; a      |
// |            non-zero divide runs a restoring divider, one quotient bit per |
// |            clock, MSB first.                                               |
// | Ports    : i_clk        clock, rising edge                                 |
// |            i_reset      synchronous active-high reset                      |
// |            bus (slave)  i_valid/o_ready request, i_op (00 add, 01 sub,     |
// |                         10 mul, 11 div), i_value_a, i_value_b;            |
// |                         o_valid/i_ready response, o_value, o_value_rem,   |
// |                         o_flag (carry / borrow / mul overflow / div by 0) |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seq_arith_unit #(
   parameter int DATA_W = 8
) (
   input  logic            i_clk,
   input  logic            i_reset,
   seq_arith_unit_if.slave bus
);

   localparam int c_cnt_w = $clog2(DATA_W);
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(DATA_W - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_div  = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   logic [1:0]          r_state;
   logic [DATA_W-1:0]   r_q;        // dividend shifting out / quotient shifting in
   logic [DATA_W-1:0]   r_b;        // divisor
   logic [DATA_W-1:0]   r_rem;      // partial remainder
   logic [c_cnt_w-1:0]  r_cnt;
   logic [DATA_W-1:0]   r_value;
   logic [DATA_W-1:0]   r_value_rem;
   logic                r_flag;

   logic [DATA_W:0]     w_sum;
   logic [2*DATA_W-1:0] w_prod;
   logic [DATA_W:0]     w_shift;
   logic                w_ge;
   logic [DATA_W-1:0]   w_sub;
   logic [DATA_W-1:0]   w_rem_next;
   logic [DATA_W-1:0]   w_q_next;

   assign w_sum  = {1'b0, bus.i_value_a} + {1'b0, bus.i_value_b};
   assign w_prod = {{DATA_W{1'b0}}, bus.i_value_a} * {{DATA_W{1'b0}}, bus.i_value_b};

   // One restoring step: bring down the next dividend bit, subtract the
   // divisor if it fits. Since the partial remainder is always below the
   // divisor, the difference fits in DATA_W bits, so only the low bits of
   // the shifted value need subtracting.
   assign w_shift    = {r_rem, r_q[DATA_W-1]};
   assign w_ge       = (w_shift >= {1'b0, r_b});
   assign w_sub      = w_shift[DATA_W-1:0] - r_b;
   assign w_rem_next = w_ge ? w_sub : w_shift[DATA_W-1:0];
   assign w_q_next   = {r_q[DATA_W-2:0], w_ge};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= c_st_idle;
         r_q         <= '0;
         r_b         <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_value     <= '0;
         r_value_rem <= '0;
         r_flag      <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (bus.i_valid) begin
                  case (bus.i_op)
                     2'b00: begin
                        r_value     <= w_sum[DATA_W-1:0];
                        r_value_rem <= '0;
                        r_flag      <= w_sum[DATA_W];
                        r_state     <= c_st_done;
                     end
                     2'b01: begin
                        r_value     <= bus.i_value_a - bus.i_value_b;
                        r_value_rem <= '0;
                        r_flag      <= (bus.i_value_a < bus.i_value_b);
                        r_state     <= c_st_done;
                     end
                     2'b10: begin
                        r_value     <= w_prod[DATA_W-1:0];
                        r_value_rem <= '0;
                        r_flag      <= |w_prod[2*DATA_W-1:DATA_W];
                        r_state     <= c_st_done;
                     end
                     default: begin
                        if (bus.i_value_b == '0) begin
                           r_value     <= '1;
                           r_value_rem <= bus.i_value_a;
                           r_flag      <= 1'b1;
                           r_state     <= c_st_done;
                        end else begin
                           // Result registers keep the previous result
                           // until the division completes.
                           r_q     <= bus.i_value_a;
                           r_b     <= bus.i_value_b;
                           r_rem   <= '0;
                           r_cnt   <= c_cnt_init;
                           r_state <= c_st_div;
                        end
                     end
                  endcase
               end
            end
            c_st_div: begin
               r_q   <= w_q_next;
               r_rem <= w_rem_next;
               r_cnt <= r_cnt - c_cnt_one;
               if (r_cnt == '0) begin
                  r_value     <= w_q_next;
                  r_value_rem <= w_rem_next;
                  r_flag      <= 1'b0;
                  r_state     <= c_st_done;
               end
            end
            c_st_done: begin
               if (bus.i_ready) begin
                  r_state <= c_st_idle;
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign bus.o_ready     = (r_state == c_st_idle);
   assign bus.o_valid     = (r_state == c_st_done);
   assign bus.o_value     = r_value;
   assign bus.o_value_rem = r_value_rem;
   assign bus.o_flag      = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_arith_unit                                               |
// | Purpose  : Self-checking bench for seq_arith_unit. Directed scenarios on   |
// |            an 8-bit instance, randomized traffic with output stalls on a  |
// |            16-bit instance against a plain-arithmetic reference model.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seq_arith_unit;

   localparam int N_RAND = 2500;

   typedef struct packed {
      logic [15:0] v;
      logic [15:0] r;
      logic        f;
   } exp_t;

   logic clk = 1'b0;
   logic rst8;
   logic rst16;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   seq_arith_unit_if #(.DATA_W(8))  if8 ();
   seq_arith_unit_if #(.DATA_W(16)) if16 ();

   seq_arith_unit #(.DATA_W(8)) dut8 (
      .i_clk   (clk),
      .i_reset (rst8),
      .bus     (if8)
   );

   seq_arith_unit #(.DATA_W(16)) dut16 (
      .i_clk   (clk),
      .i_reset (rst16),
      .bus     (if16)
   );

   // Reference: results straight from unsigned arithmetic.
   function automatic exp_t model16(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        m;
      logic [31:0] t;
      m = '0;
      case (op)
         2'd0: begin t = a + b; m.v = t[15:0]; m.f = (t > 32'd65535); end
         2'd1: begin t = a - b; m.v = t[15:0]; m.f = (a < b); end
         2'd2: begin t = a * b; m.v = t[15:0]; m.f = ((t >> 16) != 32'd0); end
         default: begin
            if (b == 32'd0) begin
               m.v = 16'hFFFF; m.r = a[15:0]; m.f = 1'b1;
            end else begin
               t = a / b; m.v = t[15:0];
               t = a % b; m.r = t[15:0];
               m.f = 1'b0;
            end
         end
      endcase
      return m;
   endfunction

   // Issue one 8-bit request with i_ready high and report when and what came back.
   task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [7:0] v, output logic [7:0] r,
                       output logic f, output logic rdy_seen);
      int w;
      lat = -1; v = '0; r = '0; f = 1'b0; rdy_seen = 1'b0;
      if8.i_ready = 1'b1;
      @(negedge clk);
      w = 0;
      while (!if8.o_ready && w < 100) begin @(negedge clk); w++; end
      if8.i_valid = 1'b1; if8.i_op = op; if8.i_value_a = a; if8.i_value_b = b;
      @(posedge clk); #1;
      if8.i_valid = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (if8.o_ready) rdy_seen = 1'b1;
         if (if8.o_valid) begin
            lat = c; v = if8.o_value; r = if8.o_value_rem; f = if8.o_flag;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      if8.i_valid = 1'b1; if8.i_op = 2'd0; if8.i_value_a = 8'd9; if8.i_value_b = 8'd9;
      if8.i_ready = 1'b1;
      if16.i_valid = 1'b0; if16.i_op = 2'd0; if16.i_value_a = '0; if16.i_value_b = '0;
      if16.i_ready = 1'b1;
      rst8 = 1'b1; rst16 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (if8.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b expected 0", if8.o_valid); end
      n_vec++; if (if8.o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b expected 1", if8.o_ready); end
      n_vec++; if ({if8.o_value, if8.o_value_rem, if8.o_flag} !== 17'd0)
         begin n_err++; $display("FAIL reset_outputs got %0d/%0d/%b expected 0/0/0", if8.o_value, if8.o_value_rem, if8.o_flag); end
      if8.i_valid = 1'b0;
      rst8 = 1'b0; rst16 = 1'b0;
      @(negedge clk);
      n_vec++; if (if8.o_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b expected 1", if8.o_ready); end
   endtask

   task automatic test_add();
      int lat; logic [7:0] v, r; logic f, rs;
      run8(2'd0, 8'd200, 8'd100, lat, v, r, f, rs);
      n_vec++; if (lat !== 1)     begin n_err++; $display("FAIL add_latency got %0d expected 1", lat); end
      n_vec++; if (v !== 8'd44)   begin n_err++; $display("FAIL add_value got %0d expected 44", v); end
      n_vec++; if (f !== 1'b1)    begin n_err++; $display("FAIL add_flag got %b expected 1", f); end
      n_vec++; if (r !== 8'd0)    begin n_err++; $display("FAIL add_rem got %0d expected 0", r); end
      @(negedge clk);
      n_vec++; if ({if8.o_ready, if8.o_valid} !== 2'b10)
         begin n_err++; $display("FAIL add_return_idle got %b expected 10", {if8.o_ready, if8.o_valid}); end
   endtask

   task automatic test_sub_mul();
      int lat; logic [7:0] v, r; logic f, rs;
      run8(2'd1, 8'd5, 8'd10, lat, v, r, f, rs);
      n_vec++; if ({v, f} !== {8'd251, 1'b1}) begin n_err++; $display("FAIL sub_5_10 got %0d/%b expected 251/1", v, f); end
      run8(2'd1, 8'd10, 8'd5, lat, v, r, f, rs);
      n_vec++; if ({v, f} !== {8'd5, 1'b0}) begin n_err++; $display("FAIL sub_10_5 got %0d/%b expected 5/0", v, f); end
      run8(2'd2, 8'd20, 8'd20, lat, v, r, f, rs);
      n_vec++; if ({v, f, lat == 1} !== {8'd144, 1'b1, 1'b1})
         begin n_err++; $display("FAIL mul_20_20 got %0d/%b lat %0d expected 144/1 lat 1", v, f, lat); end
      run8(2'd2, 8'd15, 8'd17, lat, v, r, f, rs);
      n_vec++; if ({v, f, r} !== {8'd255, 1'b0, 8'd0}) begin n_err++; $display("FAIL mul_15_17 got %0d/%b expected 255/0", v, f); end
   endtask

   task automatic test_div();
      int lat; logic [7:0] v, r; logic f, rs;
      run8(2'd3, 8'd200, 8'd7, lat, v, r, f, rs);
      n_vec++; if (lat !== 9)    begin n_err++; $display("FAIL div_latency got %0d expected 9", lat); end
      n_vec++; if (v !== 8'd28)  begin n_err++; $display("FAIL div_quot got %0d expected 28", v); end
      n_vec++; if (r !== 8'd4)   begin n_err++; $display("FAIL div_rem got %0d expected 4", r); end
      n_vec++; if (f !== 1'b0)   begin n_err++; $display("FAIL div_flag got %b expected 0", f); end
      n_vec++; if (rs !== 1'b0)  begin n_err++; $display("FAIL div_ready_busy got %b expected 0", rs); end
      run8(2'd3, 8'd255, 8'd255, lat, v, r, f, rs);
      n_vec++; if ({v, r, f} !== {8'd1, 8'd0, 1'b0}) begin n_err++; $display("FAIL div_255_255 got %0d/%0d/%b expected 1/0/0", v, r, f); end
      run8(2'd3, 8'd3, 8'd200, lat, v, r, f, rs);
      n_vec++; if ({v, r, f} !== {8'd0, 8'd3, 1'b0}) begin n_err++; $display("FAIL div_3_200 got %0d/%0d/%b expected 0/3/0", v, r, f); end
   endtask

   task automatic test_div_zero();
      int lat; logic [7:0] v, r; logic f, rs;
      run8(2'd3, 8'd77, 8'd0, lat, v, r, f, rs);
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL divz_latency got %0d expected 1", lat); end
      n_vec++; if ({v, r, f} !== {8'd255, 8'd77, 1'b1}) begin n_err++; $display("FAIL divz_result got %0d/%0d/%b expected 255/77/1", v, r, f); end
   endtask

   task automatic test_stall_hold();
      int lat, w;
      lat = -1;
      if8.i_ready = 1'b0;
      @(negedge clk);
      w = 0;
      while (!if8.o_ready && w < 100) begin @(negedge clk); w++; end
      if8.i_valid = 1'b1; if8.i_op = 2'd3; if8.i_value_a = 8'd255; if8.i_value_b = 8'd1;
      @(posedge clk); #1;
      if8.i_valid = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (if8.o_valid) begin lat = c; break; end
      end
      n_vec++; if (lat !== 9) begin n_err++; $display("FAIL stall_latency got %0d expected 9", lat); end
      for (int k = 0; k < 5; k++) begin
         if (k == 1 || k == 3) begin
            if8.i_valid = 1'b1; if8.i_op = 2'd0; if8.i_value_a = 8'd3; if8.i_value_b = 8'd4;
         end else begin
            if8.i_valid = 1'b0;
         end
         @(negedge clk);
         n_vec++;
         if ({if8.o_valid, if8.o_ready, if8.o_value, if8.o_value_rem, if8.o_flag} !== {1'b1, 1'b0, 8'd255, 8'd0, 1'b0})
            begin n_err++; $display("FAIL stall_hold_%0d got v%b r%b %0d/%0d/%b expected v1 r0 255/0/0",
                                    k, if8.o_valid, if8.o_ready, if8.o_value, if8.o_value_rem, if8.o_flag); end
      end
      if8.i_valid = 1'b0; if8.i_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({if8.o_ready, if8.o_valid, if8.o_value} !== {1'b1, 1'b0, 8'd255})
         begin n_err++; $display("FAIL stall_release got r%b v%b %0d expected r1 v0 255", if8.o_ready, if8.o_valid, if8.o_value); end
      @(negedge clk);
      n_vec++;
      if ({if8.o_ready, if8.o_valid} !== 2'b10)
         begin n_err++; $display("FAIL stall_no_accept got %b expected 10", {if8.o_ready, if8.o_valid}); end
   endtask

   task automatic test_reset_mid_div();
      int   w;
      logic seen;
      if8.i_ready = 1'b1;
      @(negedge clk);
      w = 0;
      while (!if8.o_ready && w < 100) begin @(negedge clk); w++; end
      if8.i_valid = 1'b1; if8.i_op = 2'd3; if8.i_value_a = 8'd200; if8.i_value_b = 8'd7;
      @(posedge clk); #1;
      if8.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      @(posedge clk); #1;
      rst8 = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (if8.o_valid) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b expected 0", seen); end
      n_vec++; if (if8.o_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b expected 1", if8.o_ready); end
      n_vec++; if ({if8.o_value, if8.o_value_rem, if8.o_flag} !== 17'd0)
         begin n_err++; $display("FAIL abort_outputs got %0d/%0d/%b expected 0/0/0", if8.o_value, if8.o_value_rem, if8.o_flag); end
   endtask

   task automatic test_random16();
      exp_t        q[$];
      exp_t        e;
      int          issued, done, cyc;
      logic [1:0]  op;
      logic [31:0] a, b;
      issued = 0; done = 0; cyc = 0;
      while (done < N_RAND && cyc < 80000) begin
         @(negedge clk);
         cyc++;
         if16.i_ready = ($urandom_range(0, 3) != 0);
         if (if16.o_valid && if16.i_ready) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++; $display("FAIL rand_spurious got result %0d with nothing outstanding", if16.o_value);
            end else begin
               e = q.pop_front();
               if ({if16.o_value, if16.o_value_rem, if16.o_flag} !== e)
                  begin n_err++; $display("FAIL rand_%0d got %0d/%0d/%b expected %0d/%0d/%b",
                                          done, if16.o_value, if16.o_value_rem, if16.o_flag, e.v, e.r, e.f); end
            end
            done++;
         end
         if (issued < N_RAND && $urandom_range(0, 4) != 0) begin
            op = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 65535));
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 65535));
            if (op == 2'd3 && $urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
            if16.i_valid = 1'b1; if16.i_op = op; if16.i_value_a = a[15:0]; if16.i_value_b = b[15:0];
            if (if16.o_ready) begin
               q.push_back(model16(op, a, b));
               issued++;
            end
         end else begin
            if16.i_valid = 1'b0;
         end
      end
      if16.i_valid = 1'b0;
      n_vec++;
      if (done != N_RAND) begin n_err++; $display("FAIL rand_timeout got %0d results expected %0d", done, N_RAND); end
   endtask

   initial begin
      rst8 = 1'b1; rst16 = 1'b1;
      test_reset();
      test_add();
      test_sub_mul();
      test_div();
      test_div_zero();
      test_stall_hold();
      test_reset_mid_div();
      test_random16();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
